// File: rtl/sa_cache_backing_mem.sv
// Line-granular backing memory for the set-associative cache: accepts one line
// request, waits a fixed access latency, then streams a refill or absorbs a writeback.
module sa_cache_backing_mem #(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MEM_WORDS       = 4096,
  parameter int ACCESS_LATENCY  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_last,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     done
);

  localparam int WORDS   = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
  localparam int BEAT_W  = $clog2(WORDS);
  localparam int IDX_W   = $clog2(MEM_WORDS);
  localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);
  localparam logic [7:0]        LAT_LOAD  = 8'(ACCESS_LATENCY - 1);
  localparam logic [IDX_W-1:0]  LINE_MASK = ~IDX_W'(WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t                  state_q;
  logic [7:0]              lat_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [IDX_W-1:0]        base_q;
  logic                    write_q;
  logic                    req_ready_q;
  logic                    rd_valid_q;
  logic                    rd_last_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic                    wr_ready_q;
  logic                    done_q;

  // Storage is deliberately never reset so contents survive rst.
  logic [DATA_WIDTH-1:0]   mem_q [MEM_WORDS];

  logic [ADDRESS_WIDTH-1:0] word_addr;
  logic [IDX_W-1:0]         req_base_d;
  logic [BEAT_W-1:0]        beat_d;
  logic [IDX_W-1:0]         rd_idx_d;
  logic [IDX_W-1:0]         wr_idx;
  logic                     wr_fire;
  logic                     unused_addr_bits;

  // Line base is the word index with the in-line offset cleared; index width gives the wrap.
  assign word_addr        = req_addr >> BYTE_SH;
  assign req_base_d       = word_addr[IDX_W-1:0] & LINE_MASK;
  assign unused_addr_bits = ^word_addr;

  assign beat_d   = beat_q + 1'b1;
  assign rd_idx_d = base_q + IDX_W'(beat_d);
  assign wr_idx   = base_q + IDX_W'(beat_q);
  assign wr_fire  = wr_ready_q && wr_valid;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      base_q      <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      wr_ready_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            base_q      <= req_base_d;
            write_q     <= req_write;
            lat_q       <= LAT_LOAD;
            req_ready_q <= 1'b0;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_q == 8'd0) begin
            beat_q <= '0;
            if (write_q) begin
              wr_ready_q <= 1'b1;
              state_q    <= S_WR;
            end else begin
              // First word is fetched here so rd_data is valid on entry to the burst.
              rd_valid_q <= 1'b1;
              rd_data_q  <= mem_q[base_q];
              rd_last_q  <= (LAST_BEAT == '0);
              state_q    <= S_RD;
            end
          end else begin
            lat_q <= lat_q - 8'd1;
          end
        end
        S_RD: begin
          if (rd_ready) begin
            if (beat_q == LAST_BEAT) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              beat_q    <= beat_d;
              rd_data_q <= mem_q[rd_idx_d];
              rd_last_q <= (beat_d == LAST_BEAT);
            end
          end
        end
        S_WR: begin
          if (wr_valid) begin
            if (beat_q == LAST_BEAT) begin
              wr_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              beat_q <= beat_d;
            end
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          beat_q      <= '0;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          rd_valid_q  <= 1'b0;
          rd_last_q   <= 1'b0;
          wr_ready_q  <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign rd_data   = rd_data_q;
  assign wr_ready  = wr_ready_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sa_cache_backing_mem.sv
// Directed bench for sa_cache_backing_mem: writebacks update a word model, refills
// push expected words into a scoreboard queue that is drained as beats arrive.
module tb_sa_cache_backing_mem;

  localparam int LAT   = 4;
  localparam int WORDS = 16;
  localparam int MEMW  = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_data = '0;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] model [MEMW];
  logic [31:0] exp_q [$];

  sa_cache_backing_mem #(
    .LINE_SIZE_BYTES(64),
    .DATA_WIDTH     (32),
    .ADDRESS_WIDTH  (32),
    .MEM_WORDS      (MEMW),
    .ACCESS_LATENCY (LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int line_idx(input logic [31:0] a);
    logic [31:0] w;
    w = (a >> 2) & ~32'hF;
    return int'(w % MEMW);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, ":req_ready"}, 64'(req_ready), 64'(1));
    check({tag, ":rd_valid"},  64'(rd_valid),  64'(0));
    check({tag, ":rd_last"},   64'(rd_last),   64'(0));
    check({tag, ":rd_data"},   64'(rd_data),   64'(0));
    check({tag, ":wr_ready"},  64'(wr_ready),  64'(0));
    check({tag, ":done"},      64'(done),      64'(0));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] base_val,
                          input bit gaps, input int limit, input string tag);
    int cyc, beats, first_r, last_hs, done_c, base;
    cyc = 0; beats = 0; first_r = -1; last_hs = -1; done_c = -1;
    base = line_idx(addr);
    @(negedge clk);
    check({tag, ":req_ready"}, 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
    @(posedge clk);
    #1 req_valid = 1'b0; req_write = 1'b0; req_addr = $urandom;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      wr_data  = base_val + 32'(beats);
      check({tag, ":excl"}, 64'({rd_valid, done & wr_ready}), 64'(0));
      if (wr_ready) begin
        if (first_r < 0) first_r = cyc;
        if (wr_valid) begin
          model[(base + beats) % MEMW] = wr_data;
          beats++;
          if (beats == WORDS) last_hs = cyc;
        end
      end
      if (done && done_c < 0) done_c = cyc;
      if (limit < WORDS && beats == limit) break;
      if (done_c >= 0 && req_ready) break;
    end
    check({tag, ":first_wr_ready"}, 64'(first_r), 64'(LAT + 1));
    if (limit >= WORDS) begin
      wr_valid = 1'b0;
      check({tag, ":beats"},   64'(beats),  64'(WORDS));
      check({tag, ":done_at"}, 64'(done_c), 64'(last_hs + 1));
      check({tag, ":idle_at"}, 64'(cyc),    64'(done_c + 1));
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input bit stall, input string tag);
    int cyc, beats, first_v, last_hs, done_c, base;
    bit was_stall;
    logic [32:0] held;
    cyc = 0; beats = 0; first_v = -1; last_hs = -1; done_c = -1;
    was_stall = 1'b0; held = '0;
    base = line_idx(addr);
    exp_q.delete();
    for (int k = 0; k < WORDS; k++) exp_q.push_back(model[(base + k) % MEMW]);
    @(negedge clk);
    check({tag, ":req_ready"}, 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    @(posedge clk);
    #1 req_valid = 1'b0; req_addr = $urandom;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      check({tag, ":excl"}, 64'({wr_ready, done & rd_valid}), 64'(0));
      if (rd_valid) begin
        if (first_v < 0) first_v = cyc;
        if (was_stall) check({tag, ":stall_hold"}, 64'({rd_last, rd_data}), 64'(held));
        if (exp_q.size() > 0) begin
          check({tag, ":data"}, 64'(rd_data), 64'(exp_q[0]));
          check({tag, ":last"}, 64'(rd_last), 64'(beats == WORDS - 1));
        end
        if (rd_ready) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          beats++;
          if (beats == WORDS) last_hs = cyc;
          was_stall = 1'b0;
        end else begin
          was_stall = 1'b1;
          held = {rd_last, rd_data};
        end
      end
      if (done && done_c < 0) done_c = cyc;
      if (done_c >= 0 && req_ready) break;
    end
    rd_ready = 1'b0;
    check({tag, ":first_rd_valid"}, 64'(first_v), 64'(LAT + 1));
    check({tag, ":beats"},          64'(beats),   64'(WORDS));
    check({tag, ":done_at"},        64'(done_c),  64'(last_hs + 1));
    check({tag, ":idle_at"},        64'(cyc),     64'(done_c + 1));
    if (!stall) begin
      check({tag, ":done_cycle"},  64'(done_c), 64'(LAT + WORDS + 1));
      check({tag, ":ready_cycle"}, 64'(cyc),    64'(LAT + WORDS + 2));
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_outputs("por");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("por:req_ready_after", 64'(req_ready), 64'(1));

    do_write(32'h0000_0100, 32'hA000_0000, 1'b0, WORDS, "wb100");
    do_read (32'h0000_013C, 1'b0, "rf13c");

    do_write(32'h0000_0400, 32'h5100_0000, 1'b1, WORDS, "wb400");
    do_read (32'h0000_0400, 1'b1, "rf400");

    do_write(32'h0000_FFC0, 32'hC0DE_0000, 1'b1, WORDS, "wbwrap");
    do_read (32'h0001_FFC0, 1'b0, "rfwrap");

    do_write(32'h0000_0200, 32'hB000_0000, 1'b0, WORDS, "wb200");
    do_write(32'h0000_0200, 32'hD000_0000, 1'b0, 8, "wbabort");
    // Beat 7 is accepted on this edge; reset then lands mid-cycle with wr_valid still high.
    @(posedge clk);
    #1 wr_data = 32'hDEAD_BEEF;
    #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    check("midrst:req_ready_after", 64'(req_ready), 64'(1));
    do_read(32'h0000_0200, 1'b1, "rf200");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
